// File: rtl/dlx_trace_collector.sv
// Trace/event collector for the DLX debug path: merges trace words, new event codes and
// overflow markers into one timestamped first-word-fall-through FIFO drained via valid/ready.
module dlx_trace_collector #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int TSW   = 16
) (
  input  logic           clk,
  input  logic           MRST,
  input  logic           TEN,
  input  logic           FLUSH,
  input  logic [31:0]    TP,
  input  logic           TPE,
  input  logic [9:0]     EV,
  input  logic [31:0]    Val,
  output logic           TVALID,
  input  logic           TREADY,
  output logic [1:0]     TKIND,
  output logic [TSW-1:0] TTS,
  output logic [31:0]    TDATA,
  output logic [9:0]     TEVT,
  output logic [AW:0]    LEVEL,
  output logic           OVF
);

  typedef enum logic [1:0] {
    KIND_TRACE  = 2'b00,
    KIND_EVENT  = 2'b01,
    KIND_MARKER = 2'b10
  } kind_e;

  typedef struct packed {
    kind_e          kind;
    logic [TSW-1:0] ts;
    logic [31:0]    data;
    logic [9:0]     evt;
  } entry_t;

  entry_t         mem [DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [AW:0]    level;
  logic [TSW-1:0] ts;
  logic [9:0]     ev_q;
  logic           pend;
  logic [9:0]     pend_ev;
  logic [31:0]    pend_val;
  logic [TSW-1:0] pend_ts;
  logic [15:0]    drop_cnt;
  logic           ovf;

  logic           new_ev, pop, space, push;
  logic           marker_push, event_push, trace_drop, ev_drop;
  logic [16:0]    drop_sum;
  logic [15:0]    drop_next;
  entry_t         wr_entry;

  assign new_ev = TEN && (EV != 10'd0) && (EV != ev_q);
  assign TVALID = (level != '0);
  assign pop    = TVALID && TREADY;
  assign space  = (level < (AW+1)'(DEPTH)) || pop;

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    push        = 1'b0;
    marker_push = 1'b0;
    event_push  = 1'b0;
    trace_drop  = 1'b0;
    wr_entry    = '0;
    if (TEN && TPE) begin
      wr_entry   = '{KIND_TRACE, ts, TP, 10'd0};
      push       = space;
      trace_drop = !space;
    end else if (drop_cnt != 16'd0) begin
      wr_entry    = '{KIND_MARKER, ts, {16'd0, drop_cnt}, 10'd0};
      push        = space;
      marker_push = space;
    end else if (pend) begin
      wr_entry   = '{KIND_EVENT, pend_ts, pend_val, pend_ev};
      push       = space;
      event_push = space;
    end
    // An unwritten pending event displaced by a newer one is a loss.
    ev_drop   = new_ev && pend && !event_push;
    drop_sum  = {1'b0, (marker_push ? 16'd0 : drop_cnt)} + 17'(trace_drop) + 17'(ev_drop);
    drop_next = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge MRST) begin
    if (MRST) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      ts       <= '0;
      ev_q     <= '0;
      pend     <= 1'b0;
      pend_ev  <= '0;
      pend_val <= '0;
      pend_ts  <= '0;
      drop_cnt <= '0;
      ovf      <= 1'b0;
    end else begin
      ts   <= ts + 1'b1;
      ev_q <= EV;
      if (FLUSH) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        level    <= '0;
        pend     <= 1'b0;
        drop_cnt <= '0;
        ovf      <= 1'b0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   level <= level + 1'b1;
          2'b01:   level <= level - 1'b1;
          default: level <= level;
        endcase
        if (new_ev) begin
          pend     <= 1'b1;
          pend_ev  <= EV;
          pend_val <= Val;
          pend_ts  <= ts;
        end else if (event_push) begin
          pend <= 1'b0;
        end
        drop_cnt <= drop_next;
        if (trace_drop || ev_drop) ovf <= 1'b1;
      end
    end
  end

  // NOTE: storage is deliberately not reset; entries are only observable below level.
  always_ff @(posedge clk) begin
    if (push && !FLUSH) mem[wr_ptr] <= wr_entry;
  end

  always_comb begin
    {TKIND, TTS, TDATA, TEVT} = '0;
    if (TVALID) {TKIND, TTS, TDATA, TEVT} = mem[rd_ptr];
  end

  assign LEVEL = level;
  assign OVF   = ovf;

endmodule

// File: tb/tb_dlx_trace_collector.sv
// Directed self-checking bench for dlx_trace_collector: ordering, arbitration, overflow,
// flush, pointer and timestamp wrap, and asynchronous reset.
module tb_dlx_trace_collector;

  logic        clk = 1'b0;
  logic        mrst, ten, flush, tpe, tready;
  logic [31:0] tp, val;
  logic [9:0]  ev;
  logic        tvalid, ovf;
  logic [1:0]  tkind;
  logic [15:0] tts;
  logic [31:0] tdata;
  logic [9:0]  tevt;
  logic [4:0]  level;

  int          checks   = 0;
  int          failures = 0;
  logic [15:0] tb_ts;

  dlx_trace_collector dut (
    .clk(clk), .MRST(mrst), .TEN(ten), .FLUSH(flush), .TP(tp), .TPE(tpe),
    .EV(ev), .Val(val), .TVALID(tvalid), .TREADY(tready), .TKIND(tkind),
    .TTS(tts), .TDATA(tdata), .TEVT(tevt), .LEVEL(level), .OVF(ovf)
  );

  always #5 clk = ~clk;

  // Free-running reference timestamp.
  always @(posedge clk or posedge mrst) begin
    if (mrst) tb_ts <= 16'd0;
    else      tb_ts <= tb_ts + 16'd1;
  end

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_ts(input logic [15:0] t);
    int n = 0;
    while (tb_ts !== t && n < 70000) begin
      tick();
      n++;
    end
    checks++;
    if (tb_ts !== t) begin
      failures++;
      $display("FAIL wait_ts got=%h exp=%h", tb_ts, t);
    end
  endtask

  task automatic flush_fifo;
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic test_reset;
    mrst = 1'b1; ten = 1'b0; flush = 1'b0; tpe = 1'b0; tready = 1'b0;
    tp = '0; val = '0; ev = '0;
    tick(); tick();
    checks++;
    if ({tvalid, level, ovf} !== 7'd0) begin
      failures++;
      $display("FAIL reset_status got tvalid=%0d level=%0d ovf=%0d exp=0/0/0", tvalid, level, ovf);
    end
    checks++;
    if ({tkind, tts, tdata, tevt} !== 60'd0) begin
      failures++;
      $display("FAIL reset_head got kind=%0d ts=%h data=%h evt=%h exp=0", tkind, tts, tdata, tevt);
    end
    mrst = 1'b0; ten = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (level !== 5'd0 || tvalid !== 1'b0) begin
        failures++;
        $display("FAIL idle_level got=%0d exp=0", level);
      end
    end
  endtask

  task automatic test_trace;
    tready = 1'b1;
    wait_ts(16'd7);
    for (int i = 0; i < 3; i++) begin
      tp  = 32'h11 * (i + 1);
      tpe = 1'b1;
      tick();
      checks++;
      if ({tvalid, tkind, tts, tdata, tevt} !== {1'b1, 2'b00, 16'(7 + i), 32'h11 * (i + 1), 10'd0}) begin
        failures++;
        $display("FAIL trace_%0d got v=%0d kind=%0d ts=%0d data=%h exp v=1 kind=0 ts=%0d data=%h",
                 i, tvalid, tkind, tts, tdata, 7 + i, 32'h11 * (i + 1));
      end
    end
    tpe = 1'b0;
    tick();
    checks++;
    if (level !== 5'd0 || tvalid !== 1'b0) begin
      failures++;
      $display("FAIL trace_drained got level=%0d exp=0", level);
    end
  endtask

  task automatic test_event_vs_trace;
    tready = 1'b0;
    wait_ts(16'd20);
    ev = 10'h005; val = 32'hABCD; tpe = 1'b1; tp = 32'h99;
    tick();
    tpe = 1'b0;
    tick(); tick();
    checks++;
    if (level !== 5'd2) begin
      failures++;
      $display("FAIL evtr_level got=%0d exp=2", level);
    end
    checks++;
    if ({tkind, tts, tdata, tevt} !== {2'b00, 16'd20, 32'h99, 10'd0}) begin
      failures++;
      $display("FAIL evtr_first got kind=%0d ts=%0d data=%h evt=%h exp kind=0 ts=20 data=99 evt=0",
               tkind, tts, tdata, tevt);
    end
    tready = 1'b1;
    tick();
    checks++;
    if ({tkind, tts, tdata, tevt, level} !== {2'b01, 16'd20, 32'hABCD, 10'h005, 5'd1}) begin
      failures++;
      $display("FAIL evtr_event got kind=%0d ts=%0d data=%h evt=%h level=%0d exp 1/20/abcd/5/1",
               tkind, tts, tdata, tevt, level);
    end
    tick(); tick();
    checks++;
    if (level !== 5'd0) begin
      failures++;
      $display("FAIL evtr_no_repeat got level=%0d exp=0", level);
    end
    ev = 10'd0;
  endtask

  task automatic test_event_overwrite;
    logic [15:0] s;
    logic [59:0] exp_q [5];
    tready = 1'b0;
    s = tb_ts;
    for (int i = 0; i < 3; i++) begin
      ev = 10'(i + 1); val = 32'h5000 + i; tpe = 1'b1; tp = 32'h300 + i;
      tick();
    end
    tpe = 1'b0;
    tick(); tick(); tick();
    checks++;
    if (level !== 5'd5 || ovf !== 1'b1) begin
      failures++;
      $display("FAIL ovw_level got level=%0d ovf=%0d exp 5/1", level, ovf);
    end
    exp_q[0] = {2'b00, s,          32'h300,  10'd0};
    exp_q[1] = {2'b00, s + 16'd1,  32'h301,  10'd0};
    exp_q[2] = {2'b00, s + 16'd2,  32'h302,  10'd0};
    exp_q[3] = {2'b10, s + 16'd3,  32'd2,    10'd0};
    exp_q[4] = {2'b01, s + 16'd2,  32'h5002, 10'd3};
    ev = 10'd0;
    tready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({tkind, tts, tdata, tevt} !== exp_q[i]) begin
        failures++;
        $display("FAIL ovw_entry_%0d got=%h exp=%h", i, {tkind, tts, tdata, tevt}, exp_q[i]);
      end
      tick();
    end
  endtask

  task automatic test_overflow;
    logic [15:0] s, mark_ts;
    flush_fifo();
    tready = 1'b0;
    s = tb_ts;
    for (int i = 0; i < 20; i++) begin
      tp = 32'(i); tpe = 1'b1;
      tick();
    end
    tpe = 1'b0;
    checks++;
    if (level !== 5'd16 || ovf !== 1'b1) begin
      failures++;
      $display("FAIL ovf_full got level=%0d ovf=%0d exp 16/1", level, ovf);
    end
    tready = 1'b1;
    mark_ts = tb_ts;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if ({tvalid, tkind, tts, tdata} !== {1'b1, 2'b00, s + 16'(i), 32'(i)}) begin
        failures++;
        $display("FAIL ovf_word_%0d got kind=%0d ts=%0d data=%0d exp kind=0 ts=%0d data=%0d",
                 i, tkind, tts, tdata, s + 16'(i), i);
      end
      tick();
    end
    checks++;
    if ({tvalid, tkind, tts, tdata, tevt} !== {1'b1, 2'b10, mark_ts, 32'd4, 10'd0}) begin
      failures++;
      $display("FAIL ovf_marker got v=%0d kind=%0d ts=%0d data=%0d exp v=1 kind=2 ts=%0d data=4",
               tvalid, tkind, tts, tdata, mark_ts);
    end
    tick();
    checks++;
    if (level !== 5'd0 || ovf !== 1'b1) begin
      failures++;
      $display("FAIL ovf_after got level=%0d ovf=%0d exp 0/1", level, ovf);
    end
  endtask

  task automatic test_full_pop;
    flush_fifo();
    tready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tp = 32'h100 + i; tpe = 1'b1;
      tick();
    end
    tp = 32'h200; tready = 1'b1;
    tick();
    tpe = 1'b0;
    checks++;
    if (level !== 5'd16 || ovf !== 1'b0 || tdata !== 32'h101) begin
      failures++;
      $display("FAIL full_pop got level=%0d ovf=%0d head=%h exp 16/0/101", level, ovf, tdata);
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (tdata !== ((i < 15) ? 32'h101 + i : 32'h200)) begin
        failures++;
        $display("FAIL full_drain_%0d got=%h exp=%h", i, tdata, (i < 15) ? 32'h101 + i : 32'h200);
      end
      tick();
    end
  endtask

  task automatic test_flush_wrap;
    tready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tp = 32'h400 + i; tpe = 1'b1;
      tick();
    end
    tpe = 1'b0;
    checks++;
    if (level !== 5'd10) begin
      failures++;
      $display("FAIL flush_fill got level=%0d exp=10", level);
    end
    ev = 10'h007;
    flush_fifo();
    checks++;
    if (level !== 5'd0 || tvalid !== 1'b0 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL flush_clear got level=%0d tvalid=%0d ovf=%0d exp 0/0/0", level, tvalid, ovf);
    end
    tick(); tick();
    checks++;
    if (level !== 5'd0) begin
      failures++;
      $display("FAIL flush_no_event got level=%0d exp=0", level);
    end
    ev = 10'd0;
    tready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tp = 32'h500 + i; tpe = 1'b1;
      tick();
      checks++;
      if (tdata !== 32'h500 + i || level !== 5'd1) begin
        failures++;
        $display("FAIL stream_%0d got data=%h level=%0d exp data=%h level=1", i, tdata, level, 32'h500 + i);
      end
    end
    tpe = 1'b0;
    tick();
  endtask

  task automatic test_ts_wrap;
    tready = 1'b0;
    wait_ts(16'hFFFF);
    tp = 32'hA; tpe = 1'b1;
    tick();
    tp = 32'hB;
    tick();
    tpe = 1'b0;
    checks++;
    if (level !== 5'd2 || tts !== 16'hFFFF) begin
      failures++;
      $display("FAIL wrap_before got level=%0d ts=%h exp 2/ffff", level, tts);
    end
    tready = 1'b1;
    tick();
    checks++;
    if (tts !== 16'h0000 || tdata !== 32'hB) begin
      failures++;
      $display("FAIL wrap_after got ts=%h data=%h exp 0000/b", tts, tdata);
    end
    tick();
  endtask

  task automatic test_mrst_mid;
    tready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tp = 32'h600 + i; tpe = 1'b1;
      tick();
    end
    #2 mrst = 1'b1;
    #1;
    checks++;
    if (tvalid !== 1'b0 || level !== 5'd0) begin
      failures++;
      $display("FAIL mrst_async got tvalid=%0d level=%0d exp 0/0", tvalid, level);
    end
    @(negedge clk);
    mrst = 1'b0;
    tp = 32'h777;
    tick();
    tpe = 1'b0;
    checks++;
    if ({tvalid, tkind, tts, tdata, level} !== {1'b1, 2'b00, 16'd0, 32'h777, 5'd1}) begin
      failures++;
      $display("FAIL mrst_resume got v=%0d kind=%0d ts=%0d data=%h level=%0d exp 1/0/0/777/1",
               tvalid, tkind, tts, tdata, level);
    end
  endtask

  initial begin
    test_reset();
    test_trace();
    test_event_vs_trace();
    test_event_overwrite();
    test_overflow();
    test_full_pop();
    test_flush_wrap();
    test_ts_wrap();
    test_mrst_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
